// File: rtl/microstore_sequencer_pkg.sv
// Shared control definitions for the microprogrammed control unit.
// The instruction encoder, the microstore ROM and the sequencer all use these.
package microstore_sequencer_pkg;

    localparam int STATE_W = 8;

    localparam logic [STATE_W-1:0] FETCH_STATE_DEFAULT = 8'd1;
    localparam logic [STATE_W-1:0] ABORT_STATE_DEFAULT = 8'd60;

    typedef enum logic [2:0] {
        NS_DECODE = 3'd0,
        NS_FETCH  = 3'd1,
        NS_INC    = 3'd2,
        NS_JUMP   = 3'd3,
        NS_CJUMP  = 3'd4,
        NS_CHOLD  = 3'd5,
        NS_CALL   = 3'd6,
        NS_RETURN = 3'd7
    } ns_e;

    typedef enum logic [1:0] {
        COND_SEL_MOC  = 2'd0,
        COND_SEL_COND = 2'd1,
        COND_SEL_ONE  = 2'd2,
        COND_SEL_ENCZ = 2'd3
    } cond_sel_e;

endpackage

// File: rtl/microstore_sequencer_moc_watchdog.sv
// Counts consecutive memory-wait cycles and flags a bus error once the
// wait has lasted MOC_TIMEOUT cycles without MOC arriving.
module moc_watchdog #(
    parameter int MOC_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic WAITING,
    output logic timeout,
    output logic BUS_ERR
);

    localparam logic [7:0] LIMIT = 8'(MOC_TIMEOUT - 1);

    logic [7:0] r_count;
    logic       r_bus_err;

    // Threshold reached on the last allowed wait cycle.
    always_comb begin
        timeout = WAITING && (r_count == LIMIT);
    end

    // Wait counter restarts whenever the wait breaks or the abort fires;
    // the bus error pulse is the registered abort decision.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count   <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= timeout;
            if (!WAITING || timeout) begin
                r_count <= 8'd0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign BUS_ERR = r_bus_err;

endmodule

// File: rtl/microstore_sequencer.sv
// Next-state sequencer: picks the next microstore address each cycle from
// the encoder, the microinstruction target, increment, return register or
// fixed fetch/abort addresses, and aborts stalled memory waits.
module microstore_sequencer
    import microstore_sequencer_pkg::*;
#(
    parameter logic [STATE_W-1:0] FETCH_STATE = FETCH_STATE_DEFAULT,
    parameter logic [STATE_W-1:0] ABORT_STATE = ABORT_STATE_DEFAULT,
    parameter int                 MOC_TIMEOUT = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [STATE_W-1:0] ENC_STATE,
    input  logic [2:0]         NS,
    input  logic [STATE_W-1:0] CR,
    input  logic [1:0]         COND_SEL,
    input  logic               INV,
    input  logic               MOC,
    input  logic               COND,
    output logic [STATE_W-1:0] STATE,
    output logic [STATE_W-1:0] RET,
    output logic               BUS_ERR,
    output logic               WAITING
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_ret;
    logic [STATE_W-1:0] w_inc;
    logic [STATE_W-1:0] w_next_state;
    logic [STATE_W-1:0] w_next_ret;
    logic               w_cond_src;
    logic               w_cond;
    logic               w_waiting;
    logic               w_timeout;

    // Condition source mux, optional inversion and memory-wait detection.
    always_comb begin
        w_cond_src = 1'b0;
        case (cond_sel_e'(COND_SEL))
            COND_SEL_MOC:  w_cond_src = MOC;
            COND_SEL_COND: w_cond_src = COND;
            COND_SEL_ONE:  w_cond_src = 1'b1;
            COND_SEL_ENCZ: w_cond_src = (ENC_STATE == '0);
            default:       w_cond_src = 1'b0;
        endcase
        w_cond    = w_cond_src ^ INV;
        w_waiting = (ns_e'(NS) == NS_CHOLD) && (cond_sel_e'(COND_SEL) == COND_SEL_MOC) && !w_cond;
    end

    assign w_inc   = r_state + 8'd1;
    assign WAITING = w_waiting;

    moc_watchdog #(
        .MOC_TIMEOUT (MOC_TIMEOUT)
    ) u_watchdog (
        .Clk     (Clk),
        .Reset   (Reset),
        .WAITING (w_waiting),
        .timeout (w_timeout),
        .BUS_ERR (BUS_ERR)
    );

    // Next-state decode; a memory timeout overrides whatever NS asks for.
    always_comb begin
        w_next_state = r_state;
        w_next_ret   = r_ret;
        if (w_timeout) begin
            w_next_state = ABORT_STATE;
        end else begin
            case (ns_e'(NS))
                NS_DECODE: w_next_state = (ENC_STATE == '0) ? FETCH_STATE : ENC_STATE;
                NS_FETCH:  w_next_state = FETCH_STATE;
                NS_INC:    w_next_state = w_inc;
                NS_JUMP:   w_next_state = CR;
                NS_CJUMP:  w_next_state = w_cond ? CR : w_inc;
                NS_CHOLD:  w_next_state = w_cond ? CR : r_state;
                NS_CALL: begin
                    w_next_state = CR;
                    w_next_ret   = w_inc;
                end
                NS_RETURN: w_next_state = r_ret;
                default:   w_next_state = r_state;
            endcase
        end
    end

    // State and one-deep return register update together.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ret   <= w_next_ret;
        end
    end

    assign STATE = r_state;
    assign RET   = r_ret;

endmodule
